// File: rtl/reg_file_rename_pkg.sv
// Shared widths, id types and boolean constants for the register file / rename table.
package reg_file_rename_pkg;

  localparam int unsigned ROB_WIDTH = 4;
  localparam int unsigned NREG      = 32;
  localparam int unsigned REG_WIDTH = 5;
  localparam int unsigned XLEN      = 32;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  typedef logic [ROB_WIDTH-1:0] rob_id_t;
  typedef logic [REG_WIDTH-1:0] reg_id_t;
  typedef logic [XLEN-1:0]      word_t;

endpackage

// File: rtl/reg_file_rename_if.sv
// Issue lookup, ROB operand query and commit signals between the pipeline and the register file.
interface reg_file_rename_if
  import reg_file_rename_pkg::*;
#(
  parameter int unsigned ROB_WIDTH = reg_file_rename_pkg::ROB_WIDTH
);

  logic                 IS_sgn;
  reg_id_t              IS_rs1;
  reg_id_t              IS_rs2;
  reg_id_t              IS_dest;
  logic [ROB_WIDTH-1:0] IS_ROB_name;
  logic                 IS_rdy1;
  word_t                IS_val1;
  logic [ROB_WIDTH-1:0] IS_tag1;
  logic                 IS_rdy2;
  word_t                IS_val2;
  logic [ROB_WIDTH-1:0] IS_tag2;

  logic [ROB_WIDTH-1:0] ROB_ord1;
  logic [ROB_WIDTH-1:0] ROB_ord2;
  logic                 ROB_rdy1;
  word_t                ROB_val1;
  logic                 ROB_rdy2;
  word_t                ROB_val2;

  logic                 commit_sgn;
  reg_id_t              commit_dest;
  word_t                commit_value;
  logic [ROB_WIDTH-1:0] commit_ROB_name;

  modport master (
    output IS_sgn, IS_rs1, IS_rs2, IS_dest, IS_ROB_name,
    input  IS_rdy1, IS_val1, IS_tag1, IS_rdy2, IS_val2, IS_tag2,
    input  ROB_ord1, ROB_ord2,
    output ROB_rdy1, ROB_val1, ROB_rdy2, ROB_val2,
    output commit_sgn, commit_dest, commit_value, commit_ROB_name
  );

  modport slave (
    input  IS_sgn, IS_rs1, IS_rs2, IS_dest, IS_ROB_name,
    output IS_rdy1, IS_val1, IS_tag1, IS_rdy2, IS_val2, IS_tag2,
    output ROB_ord1, ROB_ord2,
    input  ROB_rdy1, ROB_val1, ROB_rdy2, ROB_val2,
    input  commit_sgn, commit_dest, commit_value, commit_ROB_name
  );

endinterface

// File: rtl/reg_file_rename.sv
// Architectural register file with per-register busy bit and youngest-producer ROB tag;
// resolves issue operands from the file, the same-cycle commit, or the ROB.
module reg_file_rename
  import reg_file_rename_pkg::*;
#(
  parameter int unsigned ROB_WIDTH = reg_file_rename_pkg::ROB_WIDTH,
  parameter int unsigned NREG      = reg_file_rename_pkg::NREG
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rdy,
  input  logic               clear,
  reg_file_rename_if.slave   bus
);

  word_t                value [NREG];
  logic [ROB_WIDTH-1:0] tag   [NREG];
  logic [NREG-1:0]      busy;

  reg_id_t              rs      [2];
  logic                 rob_rdy [2];
  word_t                rob_val [2];
  logic                 src_rdy [2];
  word_t                src_val [2];
  logic [ROB_WIDTH-1:0] src_tag [2];

  assign rs[0]      = bus.IS_rs1;
  assign rs[1]      = bus.IS_rs2;
  assign rob_rdy[0] = bus.ROB_rdy1;
  assign rob_rdy[1] = bus.ROB_rdy2;
  assign rob_val[0] = bus.ROB_val1;
  assign rob_val[1] = bus.ROB_val2;

  // Lookup sees pre-issue state only; a same-cycle rename of the source is not visible.
  always_comb begin
    for (int unsigned n = 0; n < 2; n++) begin
      src_rdy[n] = TRUE;
      src_val[n] = '0;
      src_tag[n] = tag[rs[n]];
      if (rs[n] != '0) begin
        if (!busy[rs[n]])
          src_val[n] = value[rs[n]];
        else if (bus.commit_sgn && (bus.commit_ROB_name == tag[rs[n]]))
          src_val[n] = bus.commit_value;
        else if (rob_rdy[n])
          src_val[n] = rob_val[n];
        else
          src_rdy[n] = FALSE;
      end
    end
  end

  assign bus.IS_rdy1  = src_rdy[0];
  assign bus.IS_val1  = src_val[0];
  assign bus.IS_tag1  = src_tag[0];
  assign bus.IS_rdy2  = src_rdy[1];
  assign bus.IS_val2  = src_val[1];
  assign bus.IS_tag2  = src_tag[1];
  assign bus.ROB_ord1 = src_tag[0];
  assign bus.ROB_ord2 = src_tag[1];

  // Later assignments take precedence: commit, then flush, then rename.
  always_ff @(posedge clk) begin
    if (!rst) begin
      busy <= '0;
      for (int unsigned i = 0; i < NREG; i++) begin
        value[i] <= '0;
        tag[i]   <= '0;
      end
    end else if (rdy) begin
      if (bus.commit_sgn && (bus.commit_dest != '0)) begin
        value[bus.commit_dest] <= bus.commit_value;
        if (tag[bus.commit_dest] == bus.commit_ROB_name)
          busy[bus.commit_dest] <= FALSE;
      end
      if (clear) begin
        busy <= '0;
      end else if (bus.IS_sgn && (bus.IS_dest != '0)) begin
        busy[bus.IS_dest] <= TRUE;
        tag[bus.IS_dest]  <= bus.IS_ROB_name;
      end
    end
  end

endmodule

// File: tb/tb_reg_file_rename.sv
// Directed scoreboard bench for reg_file_rename: each cycle's expected operand lookup is queued
// by the stimulus and checked by an independent negedge monitor.
module tb_reg_file_rename;
  import reg_file_rename_pkg::*;

  typedef struct {
    string      name;
    logic       rdy1;
    logic [31:0] val1;
    logic [3:0] tag1;
    logic       rdy2;
    logic [31:0] val2;
    logic [3:0] tag2;
  } exp_t;

  logic clk;
  logic rst;
  logic rdy;
  logic clear;

  int unsigned n_checks;
  int unsigned n_fails;
  exp_t        sb [$];

  reg_file_rename_if #(.ROB_WIDTH(4)) bus ();

  reg_file_rename #(.ROB_WIDTH(4), .NREG(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .rdy   (rdy),
    .clear (clear),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      cmp({e.name, " rdy1"}, {31'd0, bus.IS_rdy1}, {31'd0, e.rdy1});
      cmp({e.name, " ord1"}, {28'd0, bus.ROB_ord1}, {28'd0, e.tag1});
      if (e.rdy1) cmp({e.name, " val1"}, bus.IS_val1, e.val1);
      else        cmp({e.name, " tag1"}, {28'd0, bus.IS_tag1}, {28'd0, e.tag1});
      cmp({e.name, " rdy2"}, {31'd0, bus.IS_rdy2}, {31'd0, e.rdy2});
      cmp({e.name, " ord2"}, {28'd0, bus.ROB_ord2}, {28'd0, e.tag2});
      if (e.rdy2) cmp({e.name, " val2"}, bus.IS_val2, e.val2);
      else        cmp({e.name, " tag2"}, {28'd0, bus.IS_tag2}, {28'd0, e.tag2});
    end
  end

  task automatic idle();
    rdy                 = 1'b1;
    clear               = 1'b0;
    bus.IS_sgn          = 1'b0;
    bus.IS_rs1          = '0;
    bus.IS_rs2          = '0;
    bus.IS_dest         = '0;
    bus.IS_ROB_name     = '0;
    bus.ROB_rdy1        = 1'b0;
    bus.ROB_val1        = '0;
    bus.ROB_rdy2        = 1'b0;
    bus.ROB_val2        = '0;
    bus.commit_sgn      = 1'b0;
    bus.commit_dest     = '0;
    bus.commit_value    = '0;
    bus.commit_ROB_name = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic issue(input logic [4:0] d, input logic [3:0] t);
    bus.IS_sgn      = 1'b1;
    bus.IS_dest     = d;
    bus.IS_ROB_name = t;
  endtask

  task automatic commit(input logic [4:0] d, input logic [31:0] v, input logic [3:0] t);
    bus.commit_sgn      = 1'b1;
    bus.commit_dest     = d;
    bus.commit_value    = v;
    bus.commit_ROB_name = t;
  endtask

  task automatic lookup(input logic [4:0] r1, input logic [4:0] r2);
    bus.IS_rs1 = r1;
    bus.IS_rs2 = r2;
  endtask

  task automatic expect_ops(input string nm,
                            input logic r1, input logic [31:0] v1, input logic [3:0] t1,
                            input logic r2, input logic [31:0] v2, input logic [3:0] t2);
    exp_t e;
    e.name = nm;
    e.rdy1 = r1; e.val1 = v1; e.tag1 = t1;
    e.rdy2 = r2; e.val2 = v2; e.tag2 = t2;
    sb.push_back(e);
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    idle();
    rst = 1'b0;
    // Reset must override a simultaneous rename and commit
    issue(5'd5, 4'd3);
    commit(5'd5, 32'h5A, 4'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    idle();

    lookup(5'd5, 5'd0);
    expect_ops("reset", 1, 32'h0, 4'd0, 1, 32'h0, 4'd0);
    tick();

    // Rename x3->2; same-cycle lookup of x3 sees the old (idle) state
    issue(5'd3, 4'd2);
    lookup(5'd3, 5'd0);
    expect_ops("rename_invisible", 1, 32'h0, 4'd0, 1, 32'h0, 4'd0);
    tick();

    lookup(5'd3, 5'd0);
    expect_ops("x3_wait_tag2", 0, 32'h0, 4'd2, 1, 32'h0, 4'd0);
    tick();

    lookup(5'd3, 5'd0);
    bus.ROB_rdy1 = 1'b1;
    bus.ROB_val1 = 32'h55;
    expect_ops("x3_rob_fwd", 1, 32'h55, 4'd2, 1, 32'h0, 4'd0);
    tick();

    issue(5'd3, 4'd5);
    tick();

    // Stale commit (tag 2) while x3 now belongs to tag 5
    commit(5'd3, 32'h10, 4'd2);
    lookup(5'd3, 5'd0);
    expect_ops("stale_commit_nobypass", 0, 32'h0, 4'd5, 1, 32'h0, 4'd0);
    tick();

    lookup(5'd3, 5'd3);
    bus.ROB_rdy2 = 1'b1;
    bus.ROB_val2 = 32'h77;
    expect_ops("x3_still_busy", 0, 32'h0, 4'd5, 1, 32'h77, 4'd5);
    tick();

    commit(5'd3, 32'h20, 4'd5);
    lookup(5'd3, 5'd0);
    expect_ops("x3_commit_bypass", 1, 32'h20, 4'd5, 1, 32'h0, 4'd0);
    tick();

    lookup(5'd3, 5'd0);
    expect_ops("x3_retired", 1, 32'h20, 4'd5, 1, 32'h0, 4'd0);
    tick();

    // Commit and rename of x4 in the same cycle: rename wins
    commit(5'd4, 32'h44, 4'd1);
    issue(5'd4, 4'd6);
    lookup(5'd0, 5'd4);
    expect_ops("x4_pre_rename", 1, 32'h0, 4'd0, 1, 32'h0, 4'd0);
    tick();

    lookup(5'd0, 5'd4);
    expect_ops("x4_busy_tag6", 1, 32'h0, 4'd0, 0, 32'h0, 4'd6);
    tick();

    // Commit bypass has priority over a ready ROB entry
    commit(5'd4, 32'h99, 4'd6);
    lookup(5'd4, 5'd4);
    bus.ROB_rdy1 = 1'b1;
    bus.ROB_val1 = 32'h11;
    expect_ops("x4_bypass_prio", 1, 32'h99, 4'd6, 1, 32'h99, 4'd6);
    tick();

    lookup(5'd4, 5'd0);
    expect_ops("x4_retired", 1, 32'h99, 4'd6, 1, 32'h0, 4'd0);
    tick();

    issue(5'd7, 4'd7);
    tick();
    issue(5'd8, 4'd8);
    tick();

    lookup(5'd7, 5'd8);
    expect_ops("x7_x8_busy", 0, 32'h0, 4'd7, 0, 32'h0, 4'd8);
    tick();

    // Flush with a same-cycle commit (value kept) and rename (dropped)
    clear = 1'b1;
    commit(5'd7, 32'hAB, 4'd3);
    issue(5'd9, 4'd9);
    tick();

    lookup(5'd7, 5'd8);
    expect_ops("after_clear", 1, 32'hAB, 4'd7, 1, 32'h0, 4'd8);
    tick();

    lookup(5'd9, 5'd0);
    expect_ops("x9_not_renamed", 1, 32'h0, 4'd0, 1, 32'h0, 4'd0);
    tick();

    // rdy low: nothing changes
    rdy = 1'b0;
    issue(5'd10, 4'd10);
    commit(5'd3, 32'hDEAD, 4'd5);
    tick();

    lookup(5'd10, 5'd3);
    expect_ops("rdy_low_hold", 1, 32'h0, 4'd0, 1, 32'h20, 4'd5);
    tick();

    // rdy low also blocks clear: x10 renamed, then a gated clear
    issue(5'd10, 4'd10);
    tick();
    rdy = 1'b0;
    clear = 1'b1;
    tick();
    lookup(5'd10, 5'd0);
    expect_ops("rdy_low_clear_hold", 0, 32'h0, 4'd10, 1, 32'h0, 4'd0);
    tick();

    // x0 is never written or renamed
    issue(5'd0, 4'd11);
    commit(5'd0, 32'h123, 4'd0);
    tick();

    lookup(5'd0, 5'd0);
    bus.ROB_rdy1 = 1'b1;
    bus.ROB_val1 = 32'hFFFF;
    expect_ops("x0_zero", 1, 32'h0, 4'd0, 1, 32'h0, 4'd0);
    tick();

    repeat (2) tick();
    n_checks++;
    if (sb.size() != 0) begin
      n_fails++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
